// File: rtl/acc_register_pkg.sv
// acc_register_pkg: shared defaults and word type for the accumulator register
package acc_register_pkg;
    localparam int DEFAULT_DATA_WIDTH = 11;
    localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_word_t;
endpackage

// File: rtl/acc_register_flags.sv
// acc_register_flags: combinational status flags of a stored data word
// Ports: i_word (DATA_WIDTH) in; o_zero, o_neg out; o_parity out only with ACC_REGISTER_PARITY_EN
module acc_register_flags
    import acc_register_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_word,
`ifdef ACC_REGISTER_PARITY_EN
    output logic                  o_parity,
`endif
    output logic                  o_zero,
    output logic                  o_neg
);
    assign o_zero = (i_word == '0);
    assign o_neg  = i_word[DATA_WIDTH-1];
`ifdef ACC_REGISTER_PARITY_EN
    assign o_parity = ^i_word;
`endif
endmodule

// File: rtl/acc_register.sv
// acc_register: write-enabled data register with ack pulse and status flags
// Ports: clock, reg_reset (sync, active-low), reg_in, reg_wr in;
//        reg_out, reg_zero, reg_neg, reg_wr_ack out.
// ACC_REGISTER_PARITY_EN adds reg_parity_in in; reg_parity, reg_parity_err out.
module acc_register
    import acc_register_pkg::*;
#(
    parameter int                  DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic                  clock,
    input  logic                  reg_reset,
    input  logic [DATA_WIDTH-1:0] reg_in,
    input  logic                  reg_wr,
`ifdef ACC_REGISTER_PARITY_EN
    input  logic                  reg_parity_in,
    output logic                  reg_parity,
    output logic                  reg_parity_err,
`endif
    output logic [DATA_WIDTH-1:0] reg_out,
    output logic                  reg_zero,
    output logic                  reg_neg,
    output logic                  reg_wr_ack
);
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ack;
    // Reset wins over a write on the same edge.
    always_ff @(posedge clock) begin
        if (!reg_reset) begin
            r_data <= RESET_VALUE;
            r_ack  <= 1'b0;
        end else begin
            r_data <= reg_wr ? reg_in : r_data;
            r_ack  <= reg_wr;
        end
    end
`ifdef ACC_REGISTER_PARITY_EN
    logic r_perr;
    // Error reflects only the most recent accepted write; holds otherwise.
    always_ff @(posedge clock) begin
        if (!reg_reset)
            r_perr <= 1'b0;
        else if (reg_wr)
            r_perr <= (^reg_in) != reg_parity_in;
    end
    assign reg_parity_err = r_perr;
`endif
    assign reg_out    = r_data;
    assign reg_wr_ack = r_ack;
    acc_register_flags #(.DATA_WIDTH(DATA_WIDTH)) u_flags (
        .i_word   (r_data),
`ifdef ACC_REGISTER_PARITY_EN
        .o_parity (reg_parity),
`endif
        .o_zero   (reg_zero),
        .o_neg    (reg_neg)
    );
endmodule

// File: tb/tb_acc_register.sv
// tb_acc_register: directed stimulus, per-cycle model comparison and literal checks
module tb_acc_register;
    localparam int W = 11;
    logic         clock = 1'b0;
    logic         reg_reset = 1'b0;
    logic [W-1:0] reg_in = '0;
    logic         reg_wr = 1'b0;
    logic [W-1:0] reg_out;
    logic         reg_zero, reg_neg, reg_wr_ack;
    int           n_pass = 0;
    int           n_total = 0;
    logic [W-1:0] m_val;
    logic         m_ack;
    logic         m_valid = 1'b0;
`ifdef ACC_REGISTER_PARITY_EN
    logic reg_parity_in = 1'b0;
    logic reg_parity, reg_parity_err;
    logic m_perr;
`endif
    acc_register #(.DATA_WIDTH(W), .RESET_VALUE('0)) dut (
        .clock      (clock),
        .reg_reset  (reg_reset),
        .reg_in     (reg_in),
        .reg_wr     (reg_wr),
`ifdef ACC_REGISTER_PARITY_EN
        .reg_parity_in  (reg_parity_in),
        .reg_parity     (reg_parity),
        .reg_parity_err (reg_parity_err),
`endif
        .reg_out    (reg_out),
        .reg_zero   (reg_zero),
        .reg_neg    (reg_neg),
        .reg_wr_ack (reg_wr_ack)
    );
    always #5 clock = ~clock;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    // Model: the stored word is whatever the last accepted write (or reset) left there.
    always @(posedge clock) begin
        m_valid <= 1'b1;
        if (!reg_reset) begin
            m_val <= '0;
            m_ack <= 1'b0;
        end else begin
            if (reg_wr) m_val <= reg_in;
            m_ack <= reg_wr;
        end
`ifdef ACC_REGISTER_PARITY_EN
        if (!reg_reset) m_perr <= 1'b0;
        else if (reg_wr) begin
            int ones;
            ones = $countones(reg_in);
            m_perr <= (ones % 2 == 1) != reg_parity_in;
        end
`endif
    end
    always @(negedge clock) begin
        if (m_valid) begin
            check("model_out", 64'(reg_out), 64'(m_val));
            check("model_zero", 64'(reg_zero), 64'(m_val == 0));
            check("model_neg", 64'(reg_neg), 64'(m_val >= 11'h400));
            check("model_ack", 64'(reg_wr_ack), 64'(m_ack));
`ifdef ACC_REGISTER_PARITY_EN
            check("model_parity", 64'(reg_parity), 64'($countones(m_val) % 2));
            check("model_perr", 64'(reg_parity_err), 64'(m_perr));
`endif
        end
    end
    task automatic cycle(input logic rst_n, input logic wr, input logic [W-1:0] din);
        reg_reset = rst_n;
        reg_wr    = wr;
        reg_in    = din;
        @(posedge clock);
        #1;
    endtask
    initial begin
        cycle(1'b0, 1'b0, 11'h032);
        check("rst_out", 64'(reg_out), 64'h0);
        check("rst_zero", 64'(reg_zero), 64'h1);
        check("rst_ack", 64'(reg_wr_ack), 64'h0);
        cycle(1'b1, 1'b1, 11'h032);
        check("wr_out", 64'(reg_out), 64'h032);
        check("wr_zero", 64'(reg_zero), 64'h0);
        check("wr_neg", 64'(reg_neg), 64'h0);
        check("wr_ack", 64'(reg_wr_ack), 64'h1);
        cycle(1'b1, 1'b0, 11'h592);
        check("hold_out", 64'(reg_out), 64'h032);
        check("hold_ack", 64'(reg_wr_ack), 64'h0);
        cycle(1'b0, 1'b0, 11'h592);
        check("rst2_out", 64'(reg_out), 64'h0);
        cycle(1'b1, 1'b0, 11'h592);
        check("release_out", 64'(reg_out), 64'h0);
        cycle(1'b1, 1'b1, 11'h592);
        check("wr2_out", 64'(reg_out), 64'h592);
        check("wr2_neg", 64'(reg_neg), 64'h1);
        cycle(1'b1, 1'b0, 11'h613);
        cycle(1'b1, 1'b0, 11'h090);
        check("nowr_out", 64'(reg_out), 64'h592);
        cycle(1'b1, 1'b0, 11'bx);
        check("x_hold_out", 64'(reg_out), 64'h592);
        cycle(1'b0, 1'b0, 11'h090);
        check("rst3_out", 64'(reg_out), 64'h0);
        check("rst3_zero", 64'(reg_zero), 64'h1);
        cycle(1'b0, 1'b1, 11'h703);
        check("prio_out", 64'(reg_out), 64'h0);
        check("prio_ack", 64'(reg_wr_ack), 64'h0);
        cycle(1'b1, 1'b1, 11'h703);
        check("after_prio_out", 64'(reg_out), 64'h703);
        check("after_prio_ack", 64'(reg_wr_ack), 64'h1);
        cycle(1'b1, 1'b1, 11'h7ff);
        check("b2b1_out", 64'(reg_out), 64'h7ff);
        check("b2b1_ack", 64'(reg_wr_ack), 64'h1);
        cycle(1'b1, 1'b1, 11'h400);
        check("b2b2_out", 64'(reg_out), 64'h400);
        check("b2b2_ack", 64'(reg_wr_ack), 64'h1);
        check("b2b2_neg", 64'(reg_neg), 64'h1);
        cycle(1'b1, 1'b0, 11'h001);
        check("b2b_end_ack", 64'(reg_wr_ack), 64'h0);
`ifdef ACC_REGISTER_PARITY_EN
        reg_parity_in = 1'b0;
        cycle(1'b1, 1'b1, 11'h032);
        check("par1", 64'(reg_parity), 64'h1);
        check("perr1", 64'(reg_parity_err), 64'h1);
        cycle(1'b1, 1'b0, 11'h000);
        check("perr_hold", 64'(reg_parity_err), 64'h1);
        cycle(1'b1, 1'b1, 11'h033);
        check("par2", 64'(reg_parity), 64'h0);
        check("perr2", 64'(reg_parity_err), 64'h0);
        cycle(1'b1, 1'b1, 11'h032);
        cycle(1'b0, 1'b0, 11'h000);
        check("perr_rst", 64'(reg_parity_err), 64'h0);
`endif
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
